// File: rtl/ruler_pkg.sv
// Shared types and helpers for the ruler stepping controller.
package ruler_pkg;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Saturate a requested position onto the last valid ruler position.
  function automatic int unsigned clamp_pos(input int unsigned pos,
                                            input int unsigned max_pos);
    return (pos > max_pos) ? max_pos : pos;
  endfunction

endpackage

// File: rtl/ruler_step_timer.sv
// Loadable down-counter that paces the gap between consecutive strobes.
module ruler_step_timer
  import ruler_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ruler_stepper.sv
// Emits rate-limited strobe/direction steps until the shadow position reaches a target.
module ruler_stepper
  import ruler_pkg::*;
#(
  parameter int unsigned RULER_WIDTH = 8,
  parameter int unsigned POS_WIDTH   = 3,
  parameter int unsigned STEP_DELAY  = 5000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [POS_WIDTH-1:0] pos_i,
  output logic                 stb_o,
  output logic                 dir_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [POS_WIDTH-1:0] cur_o
);

  localparam int unsigned          TMR_W   = $clog2(STEP_DELAY);
  localparam logic [TMR_W-1:0]     GAP_VAL = TMR_W'(STEP_DELAY - 2);
  localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(RULER_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [POS_WIDTH-1:0]   target_q, target_d;
  logic [POS_WIDTH-1:0]   cur_q, cur_d;
  logic                   dir_q, dir_d;
  logic [POS_WIDTH-1:0]   target_in;
  logic [POS_WIDTH-1:0]   step_pos;
  logic                   tmr_load;
  logic                   tmr_en;
  logic                   tmr_zero;

  assign target_in = POS_WIDTH'(clamp_pos(32'(pos_i), RULER_WIDTH - 1));

  // One position toward dir_q, saturating at both ends of the ruler.
  always_comb begin
    step_pos = cur_q;
    if (dir_q == DIR_RIGHT) begin
      if (cur_q != POS_MAX) step_pos = cur_q + 1'b1;
    end else begin
      if (cur_q != '0) step_pos = cur_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          target_d = target_in;
          if (target_in == cur_q) begin
            state_d = DONE;
          end else begin
            dir_d   = (target_in > cur_q) ? DIR_RIGHT : DIR_LEFT;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        cur_d = step_pos;
        if (step_pos == target_q) begin
          state_d = DONE;
        end else begin
          state_d  = WAIT;
          tmr_load = 1'b1;
        end
      end
      WAIT: begin
        if (tmr_zero) state_d = STEP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clr_i) begin
      state_d  = IDLE;
      cur_d    = '0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      cur_q    <= '0;
      dir_q    <= DIR_LEFT;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      dir_q    <= dir_d;
    end
  end

  assign tmr_en = (state_q == WAIT) && !clr_i;

  ruler_step_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (GAP_VAL),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign stb_o  = (state_q == STEP);
  assign busy_o = (state_q == STEP) || (state_q == WAIT);
  assign done_o = (state_q == DONE);
  assign dir_o  = dir_q;
  assign cur_o  = cur_q;

endmodule

// File: tb/tb_ruler_stepper.sv
// Scoreboard bench for ruler_stepper: stimulus queues expected strobe/done events, a monitor checks them.
module tb_ruler_stepper;

  localparam int RW = 7;
  localparam int PW = 3;
  localparam int SD = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          load_i = 1'b0;
  logic [PW-1:0] pos_i = '0;
  logic          stb_o, dir_o, busy_o, done_o;
  logic [PW-1:0] cur_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit is_done;
    bit dir;
    int cur;
    int cyc;
  } ev_t;

  ev_t sb[$];

  ruler_stepper #(
    .RULER_WIDTH (RW),
    .POS_WIDTH   (PW),
    .STEP_DELAY  (SD)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .load_i (load_i),
    .pos_i  (pos_i),
    .stb_o  (stb_o),
    .dir_o  (dir_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .cur_o  (cur_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events of a move from 'from' to 'to' loaded in cycle c; lim caps the strobes queued.
  task automatic expect_move(input int c, input int from, input int to,
                             input int lim, input bit with_done);
    ev_t e;
    int  n;
    bit  d;
    n = (to > from) ? to - from : from - to;
    d = (to > from);
    for (int k = 0; k < n && k < lim; k++) begin
      e.is_done = 1'b0;
      e.dir     = d;
      e.cur     = d ? from + k : from - k;
      e.cyc     = c + 1 + SD * k;
      sb.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.dir     = d;
      e.cur     = to;
      e.cyc     = (n == 0) ? c + 1 : c + SD * n - 2;
      sb.push_back(e);
    end
  endtask

  // Drives load for one cycle; returns with cyc = load cycle + 1.
  task automatic do_load(input int pos, input int from, input int to,
                         input int lim, input bit with_done, output int c);
    @(posedge clk_i); #1;
    c      = cyc;
    load_i = 1'b1;
    pos_i  = PW'(pos);
    expect_move(c, from, to, lim, with_done);
    @(posedge clk_i); #1;
    load_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_cur);
    check({tag, "_stb"},  stb_o,  0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_cur"},  cur_o,  exp_cur);
  endtask

  // Monitor: every strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk_i) begin
    ev_t e;
    if (!rst_i && (stb_o || done_o)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event stb=%0d done=%0d cur=%0d at cycle %0d, none expected",
                 stb_o, done_o, cur_o, cyc);
      end else begin
        e = sb.pop_front();
        check("ev_kind",  done_o, e.is_done);
        check("ev_cycle", cyc,    e.cyc);
        check("ev_cur",   cur_o,  e.cur);
        check("ev_busy",  busy_o, e.is_done ? 0 : 1);
        if (!e.is_done) check("ev_dir", dir_o, e.dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Reset state, during and after reset
    repeat (3) @(posedge clk_i);
    #1;
    check_idle("rst_hold", 0);
    check("rst_hold_dir", dir_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_idle("rst_rel", 0);
    check("rst_rel_dir", dir_o, 0);

    // 0 -> 3: strobes at +1,+5,+9, done at +10, busy over 1..9
    do_load(3, 0, 3, 99, 1'b1, c);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("busy_k%0d", k), busy_o, (k <= 9) ? 1 : 0);
      @(posedge clk_i); #1;
    end
    drain();
    check_idle("after_up", 3);

    // 3 -> 0, leftward
    do_load(0, 3, 0, 99, 1'b1, c);
    drain();
    check_idle("after_down", 0);
    check("dir_hold_left", dir_o, 0);

    // 0 -> 5, then zero-step load of 5
    do_load(5, 0, 5, 99, 1'b1, c);
    drain();
    do_load(5, 5, 5, 99, 1'b1, c);
    check("zero_busy", busy_o, 0);
    check("zero_done", done_o, 1);
    drain();
    check_idle("after_zero", 5);

    // 5 -> 6, then pos 7 clamps to 6 for a zero-step move
    do_load(6, 5, 6, 99, 1'b1, c);
    drain();
    do_load(7, 6, 6, 99, 1'b1, c);
    check("clamp_busy", busy_o, 0);
    check("clamp_done", done_o, 1);
    drain();
    check_idle("after_clamp", 6);

    // 6 -> 0, then 0 -> 6 with an ignored load while cur=1
    do_load(0, 6, 0, 99, 1'b1, c);
    drain();
    do_load(6, 0, 6, 99, 1'b1, c);
    repeat (2) @(posedge clk_i);
    #1;
    check("ign_cur", cur_o, 1);
    load_i = 1'b1;
    pos_i  = PW'(0);
    @(posedge clk_i); #1;
    load_i = 1'b0;
    drain();
    check_idle("after_ignore", 6);

    // 6 -> 0 cut by clr+load in the WAIT after the second strobe
    do_load(0, 6, 0, 2, 1'b0, c);
    repeat (6) @(posedge clk_i);
    #1;
    clr_i  = 1'b1;
    load_i = 1'b1;
    pos_i  = PW'(3);
    @(posedge clk_i); #1;
    clr_i  = 1'b0;
    load_i = 1'b0;
    check_idle("clr", 0);
    repeat (15) @(posedge clk_i);
    #1;
    check("clr_sb_empty", sb.size(), 0);
    check_idle("clr_later", 0);

    // 0 -> 4 interrupted by an asynchronous reset between strobes
    do_load(4, 0, 4, 1, 1'b0, c);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check_idle("arst", 0);
    check("arst_dir", dir_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("arst_sb_empty", sb.size(), 0);

    // After reset: 0 -> 2
    do_load(2, 0, 2, 99, 1'b1, c);
    drain();
    check_idle("after_rst_move", 2);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
